// File: rtl/memoredf_pkg.sv
// rtl/memoredf_pkg.sv - shared types and helpers for the MemorEDF queue distributor
package memoredf_pkg;

    // Per-slot occupancy: a slot either holds one word or it does not.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Width of a queue index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/distributor_if.sv
// rtl/distributor_if.sv - write-side handshake bundle between producer, distributor and per-core queues
interface distributor_if
    import memoredf_pkg::*;
#(
    parameter int QUEUE_COUNT = 7,
    parameter int DATA_WIDTH  = 32
);
    localparam int IDX_W = idx_width(QUEUE_COUNT);

    logic                   in_valid;
    logic                   in_ready;
    logic [IDX_W-1:0]       in_index;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [QUEUE_COUNT-1:0] out_valid;
    logic [QUEUE_COUNT-1:0] out_ready;
    logic [DATA_WIDTH-1:0]  out_data [QUEUE_COUNT];

    // Environment side: drives the input word and the per-queue ready lines.
    modport master (
        output in_valid, in_index, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Distributor side.
    modport slave (
        input  in_valid, in_index, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/distributor_slot.sv
// rtl/distributor_slot.sv - one registered output slot with write, drain and hold behaviour
module distributor_slot
    import memoredf_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full,
    output logic                  will_free
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Register the slot state; reset empties the slot and clears the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: a write always lands (top only writes when will_free);
    // a drain without a write empties the slot but keeps the last word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (wr_en) begin
                    state_d = SLOT_FULL;
                    data_d  = wr_data;
                end
            end
            SLOT_FULL: begin
                if (wr_en) begin
                    data_d = wr_data;
                end else if (rd_ready) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign full      = (state_q == SLOT_FULL);
    assign valid     = full;
    assign data      = data_q;
    // Slot can take a word this cycle if empty or being drained right now.
    assign will_free = ~full | rd_ready;

endmodule

// File: rtl/distributor.sv
// rtl/distributor.sv - steers tagged input words into per-queue registered slots, drops out-of-range tags
module distributor
    import memoredf_pkg::*;
#(
    parameter int QUEUE_COUNT = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    distributor_if.slave          bus,
    output logic                  drop_pulse,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int IDX_W = idx_width(QUEUE_COUNT);

    logic [QUEUE_COUNT-1:0] wr_en;
    logic [QUEUE_COUNT-1:0] full;
    logic [QUEUE_COUNT-1:0] will_free;
    logic                   oob;
    logic                   sel_free;
    logic                   accept;

    logic                   drop_pulse_q, drop_pulse_d;
    logic [DROP_WIDTH-1:0]  drop_count_q, drop_count_d;

    // Index beyond the last slot; only possible for non-power-of-two counts.
    assign oob = ({1'b0, bus.in_index} >= (IDX_W + 1)'(QUEUE_COUNT));

    // Select the will_free flag of the addressed slot without indexing out of range.
    always_comb begin
        sel_free = 1'b0;
        for (int k = 0; k < QUEUE_COUNT; k++) begin
            if (bus.in_index == IDX_W'(k)) begin
                sel_free = will_free[k];
            end
        end
    end

    assign bus.in_ready = ~reset & (oob | sel_free);
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_slot
        assign wr_en[k] = accept & ~oob & (bus.in_index == IDX_W'(k));

        distributor_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .wr_en     (wr_en[k]),
            .wr_data   (bus.in_data),
            .rd_ready  (bus.out_ready[k]),
            .valid     (bus.out_valid[k]),
            .data      (bus.out_data[k]),
            .full      (full[k]),
            .will_free (will_free[k])
        );
    end

    // Drop bookkeeping: pulse for one cycle per discarded word, count saturates.
    always_comb begin
        drop_pulse_d = 1'b0;
        drop_count_d = drop_count_q;
        if (accept && oob) begin
            drop_pulse_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    // Register the drop pulse and counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

    // Occupancy is carried on out_valid; the raw flag is kept for debug visibility.
    logic unused_full;
    assign unused_full = ^full;

endmodule

// File: tb/tb_distributor.sv
// tb/tb_distributor.sv - directed self-checking bench for the distributor
module tb_distributor;
    import memoredf_pkg::*;

    localparam int QC = 7;
    localparam int DW = 32;
    localparam int DRW = 4;

    logic           clock;
    logic           reset;
    logic           drop_pulse;
    logic [DRW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    distributor_if #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW)) bus ();

    distributor #(
        .QUEUE_COUNT (QC),
        .DATA_WIDTH  (DW),
        .DROP_WIDTH  (DRW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int idx, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_index = 3'(idx);
        bus.in_data  = d;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_index  = '0;
        bus.in_data   = '0;
        bus.out_ready = 7'h7f;

        // 1: reset for two cycles, then idle
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_drop_pulse", 64'(drop_pulse), 64'd0);

        // 2: one word per slot, all consumers ready
        for (int k = 0; k < QC; k++) begin
            drive(1'b1, k, DW'(1) << k);
            check("walk_in_ready", 64'(bus.in_ready), 64'd1);
            tick();
            check("walk_out_valid", 64'(bus.out_valid), 64'(7'(1) << k));
            check("walk_out_data", 64'(bus.out_data[k]), 64'(DW'(1) << k));
        end
        drive(1'b0, 0, '0);
        tick();
        check("walk_drained", 64'(bus.out_valid), 64'h0);

        // 3: slot 3 stalled, second write waits for the consumer
        bus.out_ready = 7'h77;
        drive(1'b1, 3, 32'hAAAA_0003);
        check("hold_first_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("hold_valid", 64'(bus.out_valid), 64'h08);
        check("hold_data", 64'(bus.out_data[3]), 64'hAAAA_0003);
        drive(1'b1, 3, 32'hBBBB_0003);
        check("hold_stall_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check("hold_stall_data", 64'(bus.out_data[3]), 64'hAAAA_0003);
        check("hold_stall_valid", 64'(bus.out_valid), 64'h08);
        bus.out_ready = 7'h7f;
        #1;
        check("hold_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("refill_valid", 64'(bus.out_valid), 64'h08);
        check("refill_data", 64'(bus.out_data[3]), 64'hBBBB_0003);
        drive(1'b0, 0, '0);
        tick();
        check("refill_drained", 64'(bus.out_valid), 64'h0);
        check("refill_keep_data", 64'(bus.out_data[3]), 64'hBBBB_0003);

        // 4: slot 2 stalled, slot 5 streams independently
        bus.out_ready = 7'h7b;
        drive(1'b1, 2, 32'h22);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5, DW'(32'h50 + i));
            check("indep_ready", 64'(bus.in_ready), 64'd1);
            tick();
            check("indep_valid", 64'(bus.out_valid), 64'h24);
            check("indep_data5", 64'(bus.out_data[5]), 64'(32'h50 + i));
            check("indep_data2", 64'(bus.out_data[2]), 64'h22);
        end
        drive(1'b0, 0, '0);
        tick();
        check("indep_slot2_held", 64'(bus.out_valid), 64'h04);
        bus.out_ready = 7'h7f;
        tick();
        check("indep_all_empty", 64'(bus.out_valid), 64'h0);

        // 5: out-of-range index is dropped and counted with saturation
        drive(1'b1, 7, 32'hDEAD);
        check("drop_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 0, '0);
        check("drop_pulse_on", 64'(drop_pulse), 64'd1);
        check("drop_count_1", 64'(drop_count), 64'd1);
        check("drop_no_valid", 64'(bus.out_valid), 64'h0);
        tick();
        check("drop_pulse_off", 64'(drop_pulse), 64'd0);
        check("drop_count_hold", 64'(drop_count), 64'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 7, 32'hDEAD);
            tick();
            check("drop_count_sat", 64'(drop_count), 64'((i + 2 > 15) ? 15 : i + 2));
        end
        check("drop_burst_pulse", 64'(drop_pulse), 64'd1);
        check("drop_burst_no_valid", 64'(bus.out_valid), 64'h0);
        drive(1'b0, 0, '0);
        tick();
        check("drop_burst_pulse_off", 64'(drop_pulse), 64'd0);

        // 6: mid-operation reset discards held words
        bus.out_ready = 7'h6e;
        drive(1'b1, 0, 32'h10);
        tick();
        drive(1'b1, 4, 32'h40);
        tick();
        drive(1'b0, 0, '0);
        check("pre_reset_valid", 64'(bus.out_valid), 64'h11);
        reset = 1'b1;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_valid", 64'(bus.out_valid), 64'h0);
        check("post_reset_count", 64'(drop_count), 64'd0);
        check("post_reset_data0", 64'(bus.out_data[0]), 64'h0);
        bus.out_ready = 7'h7f;
        drive(1'b1, 0, 32'h55);
        check("post_reset_ready", 64'(bus.in_ready), 64'd1);
        tick();
        drive(1'b0, 0, '0);
        check("post_reset_write_valid", 64'(bus.out_valid), 64'h01);
        check("post_reset_write_data", 64'(bus.out_data[0]), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/distributor.md
Name: distributor

Overview:
- Write-side counterpart of the Selector.
- Accepts one DATA_WIDTH word per cycle, tagged with a queue index, over a valid/ready handshake.
- Steers the word into one of QUEUE_COUNT registered output slots, one slot per per-core queue of the MemorEDF scheduler.
- Each slot drains through its own valid/ready handshake; out-of-range indices are dropped and counted.

Parameters:
- QUEUE_COUNT, 7, number of output slots/queues (2..16).
- DATA_WIDTH, 32, width of the data word.
- DROP_WIDTH, 16, width of the saturating drop counter.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  distributor accepts the word this cycle.
- in_index  in  $clog2(QUEUE_COUNT)  target slot.
- in_data  in  DATA_WIDTH  input word.
- out_valid  out  QUEUE_COUNT  per-slot word available.
- out_ready  in  QUEUE_COUNT  per-slot consumer takes the word.
- out_data  out  QUEUE_COUNT x DATA_WIDTH (unpacked array [QUEUE_COUNT])  per-slot word.
- drop_pulse  out  1  one-cycle pulse when an out-of-range word is discarded.
- drop_count  out  DROP_WIDTH  number of discarded words, saturating.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clock edge):
  - All out_valid=0, all out_data=0, drop_pulse=0, drop_count=0.
  - in_ready=0 while reset=1.
  - A reset asserted mid-operation discards every held word on the next edge.
- Each slot is one register (valid bit + data). Slot k state machine: EMPTY / FULL.
  - EMPTY -> FULL on an accepted write to k.
  - FULL -> EMPTY on out_valid[k] & out_ready[k] with no write to k.
  - FULL -> FULL with the new data on a simultaneous drain and write (pass-through refill).
- in_ready is combinational from registered state: in_index >= QUEUE_COUNT, OR slot[in_index] EMPTY, OR out_ready[in_index]=1. It is 0 during reset.
- An accept (in_valid & in_ready) with a valid index writes in_data into slot[in_index].
  - out_valid[k] rises on the next edge; latency is exactly 1 cycle.
  - No combinational path from in_data to out_data.
- An accept with in_index >= QUEUE_COUNT (only reachable when QUEUE_COUNT is not a power of 2):
  - The word is consumed and not stored.
  - drop_pulse=1 for the following cycle.
  - drop_count increments and saturates at all-ones; it never wraps.
- out_data[k] is held stable while out_valid[k]=1 and out_ready[k]=0 (AXI-style hold).
- After a drain without refill, out_data[k] keeps its last value; only out_valid[k] drops.
- Slots are independent: draining slot j never affects in_ready for a word targeting k≠j.
- At most one write per cycle. Any number of slots may drain in the same cycle.
- in_index and in_data may change freely while in_valid=0.

Decomposition:
- memoredf_pkg: localparam-style function for index width ($clog2 wrapper) and typedef of the slot record {valid, data}, parameterised through the module.
- One natural sub-module: distributor_slot (DATA_WIDTH). Holds one register with write/drain/hold logic and exposes full and will_free. The top instantiates QUEUE_COUNT of them in a generate loop and adds index decode, in_ready mux and the drop counter.

Test Plan:
1. Reset held 2 cycles, then released with in_valid=0 -> out_valid=0000000, drop_count=0, in_ready=1 from the first cycle after release.
2. Write data 1,2,4,8,16,32,64 to indices 0..6 on consecutive cycles, all out_ready=1 -> each out_valid[k] is high exactly one cycle, one cycle after its write, with out_data[k]=2^k.
3. out_ready[3]=0; write 0xAAAA_0003 to index 3, then 0xBBBB_0003 to index 3 -> second write sees in_ready=0 and stalls; out_data[3] holds 0xAAAA_0003. Set out_ready[3]=1 -> second word accepted in that same cycle, and out_data[3]=0xBBBB_0003 next cycle with out_valid[3] still 1.
4. Slot 2 full and stalled while writes go to index 5 -> index-5 writes are accepted every cycle and slot 2 is unchanged.
5. QUEUE_COUNT=7: write in_index=7 with data 0xDEAD -> in_ready=1, no out_valid rises, drop_pulse=1 for one cycle, drop_count=1. With DROP_WIDTH=4, 20 such writes -> drop_count=15 (saturated).
6. Slots 0 and 4 full and stalled; assert reset for 1 cycle -> next cycle out_valid=0000000 and drop_count=0; a subsequent write of 0x55 to index 0 appears 1 cycle later.
